// File: rtl/muldiv_pkg.sv
// Shared types and encodings for the sequential multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_MULTU = 1'b0;
    localparam logic OP_DIVU  = 1'b1;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;

    localparam int XLEN = 32;

    // Counter value of the final (32nd) iteration
    localparam logic [4:0] LAST_ITER = 5'd31;

endpackage

// File: rtl/muldiv_seq_if.sv
// Bus to the shared ALU: request/grant plus operands and result.
// The muldiv block is the master; the ALU/arbiter side is the slave.
interface muldiv_seq_if;
    import muldiv_pkg::*;

    logic            alu_req;
    logic            alu_gnt;
    logic [3:0]      alu_ctl;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_out;

    modport master (
        output alu_req, alu_ctl, alu_a, alu_b,
        input  alu_gnt, alu_out
    );

    modport slave (
        input  alu_req, alu_ctl, alu_a, alu_b,
        output alu_gnt, alu_out
    );

endinterface

// File: rtl/muldiv_seq.sv
// Sequential 32-bit unsigned multiply/divide using a shared external ALU.
// One shift-add (MULTU) or restoring-divide (DIVU) step per granted cycle,
// 32 steps per operation; {hi,lo} doubles as accumulator and result.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    muldiv_seq_if.master    alu
);

    state_t          state;
    state_t          state_next;
    logic            op_q;
    logic [XLEN-1:0] mcand;      // multiplicand or divisor
    logic [4:0]      cnt;

    logic [XLEN-1:0] hi_next;
    logic [XLEN-1:0] lo_next;
    logic [XLEN-1:0] div_a;      // partial remainder shifted left by one
    logic            carry;
    logic            ge;
    logic            div_zero;

    assign div_a    = {hi[XLEN-2:0], lo[XLEN-1]};
    assign div_zero = (op == OP_DIVU) && (src_b == '0);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // Next state, ALU drive and the per-iteration hi/lo update
    always_comb begin
        state_next  = state;
        alu.alu_req = 1'b0;
        alu.alu_ctl = '0;
        alu.alu_a   = '0;
        alu.alu_b   = '0;
        hi_next     = hi;
        lo_next     = lo;
        carry       = 1'b0;
        ge          = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_next = div_zero ? DONE : RUN;
            end
            RUN: begin
                alu.alu_req = 1'b1;
                if (op_q == OP_MULTU) begin
                    alu.alu_ctl = ALU_ADD;
                    alu.alu_a   = hi;
                    alu.alu_b   = lo[0] ? mcand : '0;
                    // Unsigned add overflowed iff the sum wrapped below an operand
                    carry       = (alu.alu_out < hi);
                    hi_next     = {carry, alu.alu_out[XLEN-1:1]};
                    lo_next     = {alu.alu_out[0], lo[XLEN-1:1]};
                end else begin
                    alu.alu_ctl = ALU_SUB;
                    alu.alu_a   = div_a;
                    alu.alu_b   = mcand;
                    // hi[31] means the shifted remainder is a 33-bit value,
                    // certainly >= divisor; the 32-bit difference is still exact
                    ge          = hi[XLEN-1] | (div_a >= mcand);
                    hi_next     = ge ? alu.alu_out : div_a;
                    lo_next     = {lo[XLEN-2:0], ge};
                end
                if (alu.alu_gnt && cnt == LAST_ITER)
                    state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register, operand capture and iteration commit
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_q  <= OP_MULTU;
            mcand <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= op;
                        if (div_zero) begin
                            hi <= src_a;
                            lo <= '1;
                        end else begin
                            mcand <= (op == OP_DIVU) ? src_b : src_a;
                            lo    <= (op == OP_DIVU) ? src_a : src_b;
                            hi    <= '0;
                            cnt   <= '0;
                        end
                    end
                end
                RUN: begin
                    // Without a grant the ALU result is not ours; hold everything
                    if (alu.alu_gnt) begin
                        hi  <= hi_next;
                        lo  <= lo_next;
                        cnt <= cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a behavioural shared-ALU model.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        gnt;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int n0    = 0;
    int lat;
    bit saw_req;
    bit saw_done;

    muldiv_seq_if alu_bus ();

    muldiv_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .alu   (alu_bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared ALU model
    assign alu_bus.alu_gnt = gnt;
    always_comb begin
        alu_bus.alu_out = '0;
        case (alu_bus.alu_ctl)
            ALU_ADD: alu_bus.alu_out = alu_bus.alu_a + alu_bus.alu_b;
            ALU_SUB: alu_bus.alu_out = alu_bus.alu_a - alu_bus.alu_b;
            ALU_AND: alu_bus.alu_out = alu_bus.alu_a & alu_bus.alu_b;
            ALU_OR:  alu_bus.alu_out = alu_bus.alu_a | alu_bus.alu_b;
            default: alu_bus.alu_out = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch an operation; returns at the negedge of cycle N+1
    task automatic go(input logic o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        n0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done; latency measured from the start cycle
    task automatic wait_done(output int l, output bit req);
        req = 1'b0;
        while (!done && (cyc - n0) < 200) begin
            if (alu_bus.alu_req) req = 1'b1;
            @(negedge clk);
        end
        if (alu_bus.alu_req) req = 1'b1;
        l = done ? (cyc - n0) : -1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0; gnt = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_busy",  {63'd0, busy}, 64'd0);
        chk("reset_done",  {63'd0, done}, 64'd0);
        chk("reset_hilo",  {hi, lo}, 64'd0);
        chk("reset_req",   {63'd0, alu_bus.alu_req}, 64'd0);
        rst = 1'b0;

        // reset wins over a simultaneous start
        @(negedge clk);
        rst = 1'b1; start = 1'b1; op = OP_MULTU; src_a = 32'd7; src_b = 32'd6;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_prio_busy", {63'd0, busy}, 64'd0);
        chk("rst_prio_lo",   {32'd0, lo}, 64'd0);

        // MULTU 7*6
        go(OP_MULTU, 32'd7, 32'd6);
        chk("mul_run_ctl", {59'd0, alu_bus.alu_req, alu_bus.alu_ctl}, {59'd0, 1'b1, ALU_ADD});
        chk("mul_run_b0",  {32'd0, alu_bus.alu_b}, 64'd0);
        wait_done(lat, saw_req);
        chk("mul7x6_lat",  lat, 64'd33);
        chk("mul7x6_res",  {hi, lo}, 64'd42);
        @(negedge clk);
        chk("done_pulse",  {62'd0, done, busy}, 64'd0);
        chk("idle_alu",    {alu_bus.alu_ctl, alu_bus.alu_a, alu_bus.alu_b}, 68'd0);

        // MULTU max*max exercises the carry
        go(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, saw_req);
        chk("mul_max_res", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        // DIVU 100/7
        go(OP_DIVU, 32'd100, 32'd7);
        chk("div_run_ctl", {60'd0, alu_bus.alu_ctl}, {60'd0, ALU_SUB});
        wait_done(lat, saw_req);
        chk("div100_lat",  lat, 64'd33);
        chk("div100_res",  {hi, lo}, {32'd2, 32'd14});
        repeat (3) @(negedge clk);
        chk("idle_hold",   {hi, lo}, {32'd2, 32'd14});

        // DIVU 80000000/1
        go(OP_DIVU, 32'h8000_0000, 32'd1);
        wait_done(lat, saw_req);
        chk("div_msb_res", {hi, lo}, {32'd0, 32'h8000_0000});

        // DIVU by zero
        go(OP_DIVU, 32'd1234, 32'd0);
        wait_done(lat, saw_req);
        chk("div0_lat",    lat, 64'd1);
        chk("div0_res",    {hi, lo}, {32'd1234, 32'hFFFF_FFFF});
        chk("div0_noreq",  {63'd0, saw_req}, 64'd0);

        // MULTU 3*5 with a 5-cycle grant stall and an ignored start
        go(OP_MULTU, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        gnt = 1'b0;
        start = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd0;
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("stall_busy",  {62'd0, busy, alu_bus.alu_req}, 64'd3);
        gnt = 1'b1;
        wait_done(lat, saw_req);
        chk("stall_lat",   lat, 64'd38);
        chk("stall_res",   {hi, lo}, 64'd15);

        // reset during iteration 10 aborts with no done
        go(OP_DIVU, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_state", {61'd0, busy, done, alu_bus.alu_req}, 64'd0);
        chk("abort_hilo",  {hi, lo}, 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("abort_nodone", {63'd0, saw_done}, 64'd0);
        go(OP_DIVU, 32'd9, 32'd2);
        wait_done(lat, saw_req);
        chk("div9_res",    {hi, lo}, {32'd1, 32'd4});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, one-cycle request to begin an operation.
REQ-004 SHALL have port op, input, 1, with 0 = unsigned multiply (MULTU) and 1 = unsigned divide (DIVU).
REQ-005 SHALL have port src_a, input, 32, multiplicand or dividend, sampled with start.
REQ-006 SHALL have port src_b, input, 32, multiplier or divisor, sampled with start.
REQ-007 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-008 SHALL have port done, output, 1, a one-cycle pulse when hi/lo hold the final result.
REQ-009 SHALL have ports hi and lo, output, 32 each, the result registers.
REQ-010 SHALL have port alu_req, output, 1, requesting use of the shared ALU this cycle.
REQ-011 SHALL have port alu_gnt, input, 1, granting the ALU to this block this cycle.
REQ-012 SHALL have ports alu_ctl (output, 4), alu_a and alu_b (outputs, 32), driven to the ALU when granted.
REQ-013 SHALL have port alu_out, input, 32, the ALU result, combinational in the same cycle.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-015 IDLE->RUN SHALL occur on start=1. DIVU with src_b=0 SHALL instead go IDLE->DONE.
REQ-016 On IDLE->RUN, the block SHALL load: mcand/divisor <= src_b for DIVU and src_a for MULTU; lo <= src_b for MULTU and src_a for DIVU; hi <= 0; iteration counter <= 0.
REQ-017 In RUN, alu_req SHALL be 1. An iteration SHALL complete only in a cycle with alu_gnt=1; with alu_gnt=0, all state holds.
REQ-018 MULTU iteration: alu_ctl=0 (add), alu_a=hi, alu_b = lo[0] ? mcand : 0; carry c = (alu_out < hi, unsigned); hi <= {c, alu_out[31:1]}; lo <= {alu_out[0], lo[31:1]}.
REQ-019 DIVU iteration: alu_ctl=1 (sub), alu_a={hi[30:0], lo[31]}, alu_b=divisor; ge = hi[31] | (alu_a >= divisor); hi <= ge ? alu_out : alu_a; lo <= {lo[30:0], ge}.
REQ-020 After the 32nd granted iteration (counter 31), the FSM SHALL go to DONE. In DONE, done=1 for exactly one cycle, then IDLE.
REQ-021 Latency with continuous grant: start in cycle N -> done in cycle N+33. Each cycle of alu_gnt=0 SHALL add one cycle.
REQ-022 Divide by zero: lo <= 32'hFFFFFFFF, hi <= src_a, done in cycle N+1.
REQ-023 busy SHALL be 1 in RUN and DONE and 0 in IDLE. start while busy SHALL be ignored.
REQ-024 alu_req SHALL be 0 outside RUN. alu_ctl/alu_a/alu_b SHALL be 0 whenever alu_req=0.
REQ-025 hi/lo SHALL hold the last result in IDLE until the next accepted start.
REQ-026 Final results: MULTU gives {hi,lo} = src_a*src_b (64-bit). DIVU gives lo = quotient and hi = remainder.

Reset
REQ-027 rst=1 SHALL force IDLE, hi=lo=0, counter=0, busy=done=alu_req=0, from any state including mid-RUN (the operation is aborted with no done).
REQ-028 rst SHALL take priority over start in the same cycle.

Structure
REQ-029 A shared package muldiv_pkg SHALL hold the state enum, the op encodings (OP_MULTU=0, OP_DIVU=1) and the ALU control constants (ALU_ADD=4'd0, ALU_SUB=4'd1, ALU_AND=4'd2, ALU_OR=4'd3).
REQ-030 The block SHALL be a single module with no sub-module. The ALU SHALL stay external and shared via alu_req/alu_gnt.

Verification
REQ-031 MULTU 7*6, gnt=1 always -> done at N+33, hi=0, lo=42.
REQ-032 MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001 (exercises the carry).
REQ-033 DIVU 100/7 -> lo=14, hi=2. DIVU 80000000/1 -> lo=80000000, hi=0.
REQ-034 DIVU 1234/0 -> done at N+1, lo=FFFFFFFF, hi=1234, alu_req never 1.
REQ-035 MULTU 3*5 with alu_gnt=0 for 5 cycles mid-RUN -> done at N+38, lo=15; second start during busy ignored.
REQ-036 rst=1 at RUN iteration 10 -> next cycle IDLE, hi=lo=0, no done; a new DIVU 9/2 then gives lo=4, hi=1.
